cfg_pwm_timer: RTL

- Downstream consumer of the SPI register-bank wrapper. Takes its packed config_regs bus and drives a prescaled 2-channel PWM timer.
- Returns a packed status_regs bus that the wrapper serves on SPI reads of the status half of the address map.
- All control comes from SPI-written config registers. Status is read-only timer state.

---
 rtl/cfg_pwm_timer.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/cfg_pwm_timer.sv
// Prescaled 2-channel PWM timer fed by a packed config bus; pwm_out and irq are registered, one cycle after CNT.
// Define PWM_TIMER_IRQ_EN for the masked flag interrupt; no backpressure, ena low freezes all state.
module cfg_pwm_timer #(
  parameter int NUM_CFG = 8,
  parameter int NUM_STATUS = 8,
  parameter int REG_WIDTH = 8,
  parameter logic [REG_WIDTH-1:0] ID_VALUE = 8'hA5
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            ena,
  input  logic [NUM_CFG*REG_WIDTH-1:0]    config_regs,
  output logic [NUM_STATUS*REG_WIDTH-1:0] status_regs,
  output logic [1:0]                      pwm_out,
  output logic                            irq
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t               state, state_nxt;
  logic [REG_WIDTH-1:0] ctrl, presc, period, duty0, duty1;
  logic [REG_WIDTH-1:0] pcnt, cnt, per_sh, duty0_sh, duty1_sh, wrap_cnt;
  logic                 wrap_flag, done_flag, clr_q, clr_rise;
  logic                 running, tick, wrap_ev, load_sh;
  logic [1:0]           raw, pwm_q;
  logic [2:0]           flags;

  assign ctrl   = config_regs[0*REG_WIDTH +: REG_WIDTH];
  assign presc  = config_regs[1*REG_WIDTH +: REG_WIDTH];
  assign period = config_regs[2*REG_WIDTH +: REG_WIDTH];
  assign duty0  = config_regs[3*REG_WIDTH +: REG_WIDTH];
  assign duty1  = config_regs[4*REG_WIDTH +: REG_WIDTH];

  assign clr_rise = ctrl[3] & ~clr_q;
  assign flags    = {running, done_flag, wrap_flag};

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else if (ena)
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (ctrl[0]) state_nxt = RUN;
      RUN: begin
        if (!ctrl[0])
          state_nxt = IDLE;
        else if (wrap_ev && ctrl[1])
          state_nxt = DONE;
      end
      DONE:    if (!ctrl[0]) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // A prescaler already past a freshly lowered PRESC ticks at once rather than wrapping through 255.
  always_comb begin
    running = (state == RUN);
    tick    = running && (pcnt >= presc);
    wrap_ev = tick && ctrl[0] && (cnt >= per_sh);
    load_sh = ((state == IDLE) && ctrl[0]) || wrap_ev;
    raw     = running ? {cnt < duty1_sh, cnt < duty0_sh} : 2'b00;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcnt      <= '0;
      cnt       <= '0;
      per_sh    <= '0;
      duty0_sh  <= '0;
      duty1_sh  <= '0;
      wrap_cnt  <= '0;
      wrap_flag <= 1'b0;
      done_flag <= 1'b0;
      clr_q     <= 1'b0;
      pwm_q     <= 2'b00;
    end else if (ena) begin
      clr_q <= ctrl[3];
      pwm_q <= raw ^ {2{ctrl[2]}};
      if (running && ctrl[0]) begin
        pcnt <= tick ? '0 : pcnt + 1'b1;
        if (tick)
          cnt <= wrap_ev ? '0 : cnt + 1'b1;
      end else begin
        pcnt <= '0;
        cnt  <= '0;
      end
      if (load_sh) begin
        per_sh   <= period;
        duty0_sh <= duty0;
        duty1_sh <= duty1;
      end
      if (clr_rise) begin
        wrap_flag <= 1'b0;
        done_flag <= 1'b0;
        wrap_cnt  <= '0;
      end
      // A wrap in the same cycle as a clear still counts as the first wrap.
      if (wrap_ev) begin
        wrap_flag <= 1'b1;
        wrap_cnt  <= clr_rise ? REG_WIDTH'(1) : wrap_cnt + 1'b1;
        if (ctrl[1])
          done_flag <= 1'b1;
      end
    end
  end

  assign pwm_out = pwm_q;

`ifdef PWM_TIMER_IRQ_EN
  logic [REG_WIDTH-1:0] irq_mask;
  logic                 irq_q;
  logic                 unused_cfg;

  assign irq_mask   = config_regs[5*REG_WIDTH +: REG_WIDTH];
  assign unused_cfg = ^{config_regs[NUM_CFG*REG_WIDTH-1:6*REG_WIDTH], ctrl[REG_WIDTH-1:4],
                        irq_mask[REG_WIDTH-1:3]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      irq_q <= 1'b0;
    else if (ena)
      irq_q <= |(flags & irq_mask[2:0]);
  end

  assign irq = irq_q;
`else
  logic unused_cfg;

  assign unused_cfg = ^{config_regs[NUM_CFG*REG_WIDTH-1:5*REG_WIDTH], ctrl[REG_WIDTH-1:4]};
  assign irq        = 1'b0;
`endif

  assign status_regs = {{REG_WIDTH{1'b0}}, ID_VALUE, duty1_sh, duty0_sh, per_sh, wrap_cnt,
                        {{(REG_WIDTH-3){1'b0}}, flags}, cnt};

endmodule
